matrix_command_sequencer: RTL and testbench

MATRIX_COMMAND_SEQUENCER -- requirements
Module: matrix_command_sequencer

---
 rtl/matrix_command_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_matrix_command_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/matrix_command_sequencer.sv
// Matrix command sequencer. It reads one header word and NUM_OPS operand
// address words from a command buffer, then hands the operand addresses to a
// loader one at a time and waits for the loader to finish.
// Optional build macro: CMD_TIMEOUT_EN adds a watchdog that aborts a loader
// that stays silent for TIMEOUT_CYC cycles.
module matrix_command_sequencer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 15,
    parameter int NUM_OPS     = 3,
    parameter int OPC_W       = 4,
    parameter int MAX_OPC     = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              ld_enable,
    output logic [OPC_W-1:0]  ld_opcode,
    output logic [ADDR_W-1:0] ld_start_addr,
    input  logic              ld_next_req,
    output logic              ld_next_ack,
    input  logic              ld_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t                         state;
    logic [IDX_W-1:0]               idx;
    logic [NUM_OPS-1:0][ADDR_W-1:0] addr_mem;

    logic              accept;
    logic [OPC_W-1:0]  hdr_opc;
    logic [ADDR_W-1:0] word_addr;
    logic              tmo_hit;

    assign accept    = cmd_valid && cmd_ready;
    assign hdr_opc   = cmd_data[OPC_W-1:0];
    assign word_addr = cmd_data[ADDR_W-1:0];

    // Upper command bits carry no meaning for this block.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_data;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_run;

    assign in_run  = (state == ISSUE) || (state == WAIT_DONE);
    assign tmo_hit = in_run && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts silent cycles while the loader owns the command.
    always_ff @(posedge clock) begin
        if (reset || !in_run || ld_next_req || ld_done) tmo_cnt <= '0;
        else                                            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
    assign tmo_hit        = 1'b0;
`endif

    // Operand storage, written only while collecting a legal command.
    always_ff @(posedge clock) begin
        if (state == LOAD && accept) addr_mem[idx] <= word_addr;
    end

    // Main sequencer FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            cmd_ready     <= 1'b1;
            ld_enable     <= 1'b0;
            ld_opcode     <= '0;
            ld_start_addr <= '0;
            ld_next_ack   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'b00;
        end else begin
            ld_next_ack <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx <= '0;
                        if (hdr_opc == '0) begin
                            done <= 1'b1;
                        end else if (hdr_opc <= OPC_W'(MAX_OPC)) begin
                            ld_opcode <= hdr_opc;
                            err       <= 1'b0;
                            err_code  <= 2'b00;
                            state     <= LOAD;
                            busy      <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                            state    <= DRAIN;
                            busy     <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            // addr_mem[0] was written on an earlier accept.
                            idx           <= '0;
                            state         <= ISSUE;
                            cmd_ready     <= 1'b0;
                            ld_enable     <= 1'b1;
                            ld_start_addr <= addr_mem[0];
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (ld_done) begin
                        // Loader finished before consuming every operand.
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        ld_enable <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        err_code  <= 2'b10;
                        idx       <= '0;
                    end else if (ld_next_req) begin
                        ld_start_addr <= addr_mem[idx + 1'b1];
                        ld_next_ack   <= 1'b1;
                        idx           <= idx + 1'b1;
                        if (idx + 1'b1 == LAST_IDX) state <= WAIT_DONE;
                    end else if (tmo_hit) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        ld_enable <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        err_code  <= 2'b11;
                        idx       <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (ld_done || tmo_hit) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        ld_enable <= 1'b0;
                        done      <= 1'b1;
                        idx       <= '0;
                        if (!ld_done) begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    ld_enable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_command_sequencer.sv
// Directed bench for matrix_command_sequencer (NUM_OPS=3, MAX_OPC=3,
// TIMEOUT_CYC=16). Inputs change 1 ns after the rising edge, outputs are
// sampled at the same point.
module tb_matrix_command_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        ld_enable;
    logic [3:0]  ld_opcode;
    logic [14:0] ld_start_addr;
    logic        ld_next_req = 1'b0;
    logic        ld_next_ack;
    logic        ld_done = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;

    matrix_command_sequencer #(
        .DATA_W(32), .ADDR_W(15), .NUM_OPS(3), .OPC_W(4), .MAX_OPC(3), .TIMEOUT_CYC(16)
    ) dut (
        .clock(clock), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .ld_enable(ld_enable), .ld_opcode(ld_opcode),
        .ld_start_addr(ld_start_addr), .ld_next_req(ld_next_req), .ld_next_ack(ld_next_ack),
        .ld_done(ld_done), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin step(); n++; end
        checks++; if (n >= 50) begin failures++; $display("FAIL send_ready got=%0b exp=1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_req();
        ld_next_req = 1'b1; step(); ld_next_req = 1'b0;
    endtask

    task automatic pulse_done();
        ld_done = 1'b1; step(); ld_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (ld_enable !== 1'b0) begin failures++; $display("FAIL rst_en got=%0b exp=0", ld_enable); end
        checks++; if (done !== 1'b0 || ld_next_ack !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%0b%0b exp=00", done, ld_next_ack); end
        checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL rst_err got=%0b/%0b exp=0/00", err, err_code); end
        checks++; if (ld_start_addr !== 15'h0 || ld_opcode !== 4'h0) begin failures++; $display("FAIL rst_regs got=%0h/%0h exp=0/0", ld_start_addr, ld_opcode); end
    endtask

    task automatic test_normal();
        send(32'h2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hdr_busy got=%0b exp=1", busy); end
        send(32'hFFFF_0100); send(32'h0200); send(32'h0300);
        checks++; if (ld_enable !== 1'b1) begin failures++; $display("FAIL issue_en got=%0b exp=1", ld_enable); end
        checks++; if (ld_start_addr !== 15'h0100) begin failures++; $display("FAIL issue_addr0 got=%0h exp=100", ld_start_addr); end
        checks++; if (ld_opcode !== 4'h2) begin failures++; $display("FAIL issue_opc got=%0h exp=2", ld_opcode); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL issue_ready got=%0b exp=0", cmd_ready); end
        pulse_req();
        checks++; if (ld_next_ack !== 1'b1 || ld_start_addr !== 15'h0200) begin failures++; $display("FAIL ack1 got=%0b/%0h exp=1/200", ld_next_ack, ld_start_addr); end
        step();
        checks++; if (ld_next_ack !== 1'b0) begin failures++; $display("FAIL ack1_pulse got=%0b exp=0", ld_next_ack); end
        pulse_req();
        checks++; if (ld_next_ack !== 1'b1 || ld_start_addr !== 15'h0300) begin failures++; $display("FAIL ack2 got=%0b/%0h exp=1/300", ld_next_ack, ld_start_addr); end
        pulse_req();
        checks++; if (ld_next_ack !== 1'b0 || ld_start_addr !== 15'h0300) begin failures++; $display("FAIL wait_req_ignored got=%0b/%0h exp=0/300", ld_next_ack, ld_start_addr); end
        checks++; if (ld_opcode !== 4'h2 || ld_enable !== 1'b1) begin failures++; $display("FAIL wait_hold got=%0h/%0b exp=2/1", ld_opcode, ld_enable); end
        pulse_done();
        checks++; if (done !== 1'b1 || ld_enable !== 1'b0) begin failures++; $display("FAIL fin got=%0b/%0b exp=1/0", done, ld_enable); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL fin_idle got=%0b%0b%0b exp=010", busy, cmd_ready, err); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL fin_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_bad_opcode();
        int seen_en;
        int seen_done;
        seen_en = 0; seen_done = 0;
        send(32'h9);
        checks++; if (err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL bad_err got=%0b/%0b exp=1/01", err, err_code); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bad_busy got=%0b exp=1", busy); end
        for (int i = 0; i < 3; i++) begin
            send(32'h0500 + i);
            if (ld_enable) seen_en++;
            if (done) seen_done++;
        end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL drain_idle got=%0b/%0b exp=0/1", busy, cmd_ready); end
        step();
        if (done) seen_done++;
        checks++; if (seen_en != 0 || seen_done != 0) begin failures++; $display("FAIL drain_quiet got=%0d/%0d exp=0/0", seen_en, seen_done); end
        checks++; if (err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL drain_sticky got=%0b/%0b exp=1/01", err, err_code); end
    endtask

    task automatic test_nop();
        send(32'h0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL nop got=%0b/%0b exp=1/0", done, busy); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL nop_after got=%0b/%0b exp=0/0", done, busy); end
    endtask

    task automatic test_early_done();
        send(32'h1);
        checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL hdr_clr got=%0b/%0b exp=0/00", err, err_code); end
        send(32'h0A); send(32'h0B); send(32'h0C);
        pulse_req();
        checks++; if (ld_next_ack !== 1'b1 || ld_start_addr !== 15'h000B) begin failures++; $display("FAIL early_ack got=%0b/%0h exp=1/b", ld_next_ack, ld_start_addr); end
        pulse_done();
        checks++; if (done !== 1'b1 || ld_enable !== 1'b0 || err !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL early got=%0b%0b%0b/%0b exp=101/10", done, ld_enable, err, err_code); end
        // Same-cycle request and done: done wins.
        send(32'h3); send(32'h1); send(32'h2); send(32'h3);
        ld_next_req = 1'b1; ld_done = 1'b1; step(); ld_next_req = 1'b0; ld_done = 1'b0;
        checks++; if (ld_next_ack !== 1'b0 || done !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL simul got=%0b/%0b/%0b exp=0/1/10", ld_next_ack, done, err_code); end
        checks++; if (ld_start_addr !== 15'h0001 || busy !== 1'b0) begin failures++; $display("FAIL simul_state got=%0h/%0b exp=1/0", ld_start_addr, busy); end
    endtask

    task automatic test_reset_mid();
        send(32'h2); send(32'h77); send(32'h88);
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_rst got=%0b%0b%0b%0b exp=0100", busy, cmd_ready, done, err); end
        send(32'h3); send(32'h11); send(32'h22); send(32'h33);
        checks++; if (ld_enable !== 1'b1 || ld_start_addr !== 15'h0011 || ld_opcode !== 4'h3) begin failures++; $display("FAIL mid_issue got=%0b/%0h/%0h exp=1/11/3", ld_enable, ld_start_addr, ld_opcode); end
        pulse_req();
        checks++; if (ld_start_addr !== 15'h0022) begin failures++; $display("FAIL mid_a1 got=%0h exp=22", ld_start_addr); end
        pulse_req();
        checks++; if (ld_start_addr !== 15'h0033) begin failures++; $display("FAIL mid_a2 got=%0h exp=33", ld_start_addr); end
        pulse_done();
        checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_fin got=%0b/%0b/%0b exp=1/0/0", done, err, busy); end
    endtask

    task automatic test_timeout();
        send(32'h1); send(32'h5); send(32'h6); send(32'h7);
`ifdef CMD_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        checks++; if (ld_enable !== 1'b1) begin failures++; $display("FAIL tmo_early got=%0b exp=1", ld_enable); end
        step();
        checks++; if (ld_enable !== 1'b0 || done !== 1'b1 || err !== 1'b1 || err_code !== 2'b11) begin failures++; $display("FAIL tmo got=%0b%0b%0b/%0b exp=011/11", ld_enable, done, err, err_code); end
`else
        for (int i = 0; i < 100; i++) step();
        checks++; if (ld_enable !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL no_tmo got=%0b%0b%0b exp=110", ld_enable, busy, err); end
        pulse_done();
        checks++; if (done !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL no_tmo_end got=%0b/%0b exp=1/10", done, err_code); end
`endif
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_opcode();
        test_nop();
        test_early_done();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
